// File: rtl/clkdiv_pkg.sv
// Shared widths and 100 MHz half-period constants for the clock-divider bank.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DFLT = 27;
    localparam int unsigned CH_IDX_W   = 4;
    localparam int unsigned MAX_CH     = 16;

    // Half-period values are in master clocks minus one.
    localparam int unsigned HALF_1HZ   = 49999999;
    localparam int unsigned HALF_2HZ   = 24999999;
    localparam int unsigned HALF_5HZ   = 9999999;
    localparam int unsigned HALF_500HZ = 99999;

    // True when a config index addresses an implemented channel.
    function automatic logic ch_exists(input logic [CH_IDX_W-1:0] ch,
                                       input int unsigned         num_ch);
        return (32'(ch) < num_ch);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, half-period register, square-wave flop.
// Optional rising-edge strobe is built only when CLKDIV_TICK_EN is defined.
module clkdiv_channel #(
    parameter int unsigned           CNT_W      = 27,
    parameter logic [CNT_W-1:0]      RESET_HALF = CNT_W'(49999999)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             div_out,
    output logic             tick
);

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic             wrap_c;

    assign wrap_c = (cnt == half);

    // A write or sync restarts the channel from the low phase; reset wins over both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half    <= RESET_HALF;
            cnt     <= '0;
            div_out <= 1'b0;
        end else if (wr || restart) begin
            if (wr) begin
                half <= wr_half;
            end
            cnt     <= '0;
            div_out <= 1'b0;
        end else if (en) begin
            if (wrap_c) begin
                cnt     <= '0;
                div_out <= ~div_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef CLKDIV_TICK_EN
    // Strobe on the edge where div_out goes high; restarts never raise it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= en && !wr && !restart && wrap_c && !div_out;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_bank.sv
// Multi-channel 50% duty clock divider with runtime config port and global sync.
// Build with CLKDIV_TICK_EN defined to generate the per-channel rising-edge tick strobes.
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = CNT_W_DFLT,
    parameter int unsigned RESET_HALF = HALF_1HZ
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   en,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic                cfg_ready,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   div_out,
    output logic [NUM_CH-1:0]   tick
);

    logic cfg_wr_c;
    logic ch_ok_c;

    assign cfg_wr_c = cfg_valid && cfg_ready;
    assign ch_ok_c  = ch_exists(cfg_ch, NUM_CH);

    // Port is ready from the first edge out of reset; bad-index writes pulse cfg_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_wr_c && !ch_ok_c;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_c;

        assign wr_c = cfg_wr_c && ch_ok_c && (cfg_ch == CH_IDX_W'(i));

        clkdiv_channel #(
            .CNT_W      (CNT_W),
            .RESET_HALF (CNT_W'(RESET_HALF))
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .restart (sync),
            .wr      (wr_c),
            .wr_half (cfg_half),
            .div_out (div_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Scoreboard bench for clkdiv_bank: stimulus pushes expected outputs, monitor pops and compares.
module tb_clkdiv_bank;

    localparam int N  = 4;
    localparam int CW = 27;
    localparam longint RH = 49999999;
`ifdef CLKDIV_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] div;
        logic [N-1:0] tick;
        logic         err;
        logic         ready;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  en = '0;
    logic          sync = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [3:0]    cfg_ch = '0;
    logic [CW-1:0] cfg_half = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic [N-1:0]  div_out;
    logic [N-1:0]  tick;

    int checks = 0;
    int errors = 0;

    exp_t   exp_q[$];
    longint k[N];
    longint h[N];
    logic   mready = 1'b0;

    clkdiv_bank #(.NUM_CH(N), .CNT_W(CW), .RESET_HALF(49999999)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_out   (div_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: sample 1 time unit after each active edge and compare against the queue head.
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("div_out",   8'(div_out),   8'(ex.div));
            chk("tick",      8'(tick),      8'(ex.tick));
            chk("cfg_err",   8'(cfg_err),   8'(ex.err));
            chk("cfg_ready", 8'(cfg_ready), 8'(ex.ready));
        end
    end

    // Drive one edge of stimulus and push the expected post-edge outputs.
    // Expected wave: after k enabled edges since restart, level = floor(k/(h+1)) mod 2.
    task automatic step(input logic r, input logic [N-1:0] e, input logic s,
                        input logic v, input logic [3:0] c, input logic [CW-1:0] hv);
        exp_t ex;
        logic wr;
        logic inc;
        @(negedge clk);
        rst_n = r; en = e; sync = s; cfg_valid = v; cfg_ch = c; cfg_half = hv;
        ex = '0;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                h[i] = RH;
                k[i] = 0;
            end
            mready = 1'b0;
        end else begin
            wr = v && mready;
            ex.err = wr && (int'(c) >= N);
            for (int i = 0; i < N; i++) begin
                inc = 1'b0;
                if ((wr && int'(c) == i) || s) begin
                    if (wr && int'(c) == i) h[i] = longint'(hv);
                    k[i] = 0;
                end else if (e[i]) begin
                    k[i]++;
                    inc = 1'b1;
                end
                ex.tick[i] = TICK_ON && inc && ((k[i] % (2 * (h[i] + 1))) == h[i] + 1);
            end
            mready = 1'b1;
        end
        for (int i = 0; i < N; i++) ex.div[i] = ((k[i] / (h[i] + 1)) % 2) == 1;
        ex.ready = mready;
        exp_q.push_back(ex);
    endtask

    task automatic run(input int n, input logic [N-1:0] e);
        for (int j = 0; j < n; j++) step(1'b1, e, 1'b0, 1'b0, 4'd0, '0);
    endtask

    task automatic cfg(input logic [N-1:0] e, input logic [3:0] c, input logic [CW-1:0] hv);
        step(1'b1, e, 1'b0, 1'b1, c, hv);
    endtask

    initial begin
        int wait_cyc;
        // Reset then run ch0 at half=3 (period 8)
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 4'd0, '0);
        // Write presented while cfg_ready is still low is not accepted
        cfg(4'b0000, 4'd0, CW'(3));
        cfg(4'b0001, 4'd0, CW'(3));
        run(20, 4'b0001);
        // ch1 at half=0 (clk/2)
        cfg(4'b0011, 4'd1, CW'(0));
        run(10, 4'b0011);
        // Mid-count reprogram of ch0: half=9, count to 6, then half=2
        cfg(4'b0011, 4'd0, CW'(9));
        run(6, 4'b0011);
        cfg(4'b0011, 4'd0, CW'(2));
        run(14, 4'b0001);
        // Sync alignment: ch0 half=2, ch2 half=4 out of phase
        cfg(4'b0101, 4'd2, CW'(4));
        run(7, 4'b0101);
        step(1'b1, 4'b0101, 1'b1, 1'b0, 4'd0, '0);
        run(35, 4'b0101);
        // Bad channel indices: err pulse, no state change
        cfg(4'b0101, 4'd7, CW'(5));
        run(3, 4'b0101);
        cfg(4'b0101, 4'd15, CW'(1));
        run(2, 4'b0101);
        // Enable hold on ch0 for 5 cycles, resume without restart
        run(5, 4'b0100);
        run(10, 4'b0101);
        // ch3 half=1 tick stream, then sync and cfg restarts
        cfg(4'b1101, 4'd3, CW'(1));
        run(12, 4'b1101);
        step(1'b1, 4'b1101, 1'b1, 1'b0, 4'd0, '0);
        run(6, 4'b1101);
        cfg(4'b1101, 4'd3, CW'(1));
        run(6, 4'b1101);
        // Sync and write on the same edge both apply
        step(1'b1, 4'b1111, 1'b1, 1'b1, 4'd1, CW'(2));
        run(12, 4'b1111);
        // Reset mid-operation overrides a write and sync on the same edge
        step(1'b0, 4'b1111, 1'b1, 1'b1, 4'd0, CW'(0));
        run(4, 4'b1111);
        cfg(4'b1111, 4'd0, CW'(1));
        run(8, 4'b1111);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
